uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised, run-time-configurable UART receiver for the serial I/O subsystem. It is driven by the shared baud-rate oversampling tick. It adds the following over the basic receiver:
- input synchronisation
- 3-sample majority voting
- false-start rejection
- optional parity
- one or two stop bits
- parity, framing and break error reporting

Parameters:
DBIT, 8, data bits per frame (5..9), sent LSB first
OS_TICK, 16, s_tick pulses per bit period (even, >= 8)
SYNC_STAGES, 2, flip-flops in the rx synchroniser (>= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  serial line, asynchronous to clk, idles high
s_tick  in  1  oversampling strobe, one clk wide
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  in  1  0 = one stop bit, 1 = two stop bits
rx_done_tick  out  1  one-clk pulse, frame complete
dout  out  DBIT  received data, held until the next completed frame
parity_err  out  1  parity error of the last frame
frame_err  out  1  stop-bit error of the last frame
break_det  out  1  break condition detected on the last frame

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, counters = 0, synchroniser flops = 1.
  - All outputs are 0. dout = 0.
  - Reset mid-frame aborts the frame; no rx_done_tick is generated.
- rx_s is rx after SYNC_STAGES flops. All decisions use rx_s only.
- Counters: s counter is clog2(OS_TICK) bits; n counter is clog2(DBIT) bits. Both advance only on s_tick.
- States: IDLE, START, DATA, PARITY, STOP, RECOVER.
- IDLE:
  - rx_s == 0 → START, s = 0.
  - parity_mode and two_stop are latched at this point. Changes mid-frame are ignored.
- START:
  - On the s_tick where s == OS_TICK/2-1, check rx_s.
  - rx_s == 1: false start → IDLE, no outputs change.
  - rx_s == 0: → DATA, s = 0, n = 0.
- Bit sampling (DATA, PARITY, STOP):
  - Capture rx_s on the ticks where s == OS_TICK-3, OS_TICK-2 and OS_TICK-1.
  - Bit value = majority of the 3 samples, resolved on the s == OS_TICK-1 tick.
  - s wraps to 0 on that tick.
- DATA:
  - The voted bit shifts in MSB-side, so the first received bit ends in dout[0].
  - After bit DBIT-1: → PARITY if the latched mode is 01/10, otherwise → STOP.
- PARITY:
  - Voted bit is stored.
  - Error if XOR(data bits, parity bit) is 1 for even mode, or 0 for odd mode.
  - → STOP.
- STOP:
  - One or two stop bit periods, per latched two_stop.
  - Any voted stop bit == 0 sets the frame error.
  - With two_stop, both stop bits are always sampled even if the first fails.
- Frame completion (clock edge after the final stop-bit decision):
  - rx_done_tick = 1 for exactly one clk.
  - dout, parity_err and frame_err update in the same cycle and are held until the next completion.
  - parity_err = 0 when parity is disabled.
- break_det = frame_err AND all data bits 0 AND (parity disabled OR parity bit 0).
- Next state after completion:
  - → RECOVER if frame_err, otherwise → IDLE.
  - RECOVER waits for rx_s == 1, then → IDLE. This prevents immediate re-triggering on a held-low line.
- s_tick low: state and counters hold. Unused encodings → IDLE.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams
  - parity mode constants: PAR_NONE, PAR_EVEN, PAR_ODD
  - a clog2 function
- One sub-module, uart_rx_sync:
  - SYNC_STAGES synchroniser with reset value 1
  - 3-sample majority voter with sample-enable inputs
  - outputs rx_s and the voted bit

Test Plan:
All scenarios use DBIT=8, OS_TICK=16, s_tick every clk.
- 8N1 frame 0x55 → one rx_done_tick; dout=0x55; parity_err=0, frame_err=0, break_det=0.
- Even parity, frame 0xA3 with parity bit 1 (correct bit is 0) → dout=0xA3, parity_err=1. Same frame with odd mode → parity_err=0.
- Start-bit glitch (rx low for 4 ticks in IDLE) → no rx_done_tick; state returns to IDLE; the next frame 0x3C is received correctly.
- 2-tick low glitch centred on the sampling window of data bit 3 of 0xFF → majority vote rejects it; dout=0xFF, no errors.
- Line held low for 20 bit periods → frame_err=1, break_det=1, dout=0x00. No second rx_done_tick until rx returns high; the following frame 0x81 is received correctly.
- two_stop=1 with the second stop bit low on frame 0x12 → frame_err=1, dout=0x12. In a separate run, reset asserted mid-DATA → all outputs 0 and no done pulse; the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding, parity-mode constants and a width helper for the
// configurable UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP    = 3'd4,
      ST_RECOVER = 3'd5
   } rx_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Bits needed to count 0..value-1; never less than 1 so vectors stay legal.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings rx into the clk domain and majority-votes three consecutive samples;
// the third sample is the live rx_s, so the vote is valid on the last sample tick.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   input  logic sample_en,
   output logic rx_s,
   output logic voted
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             samp_q, samp_d;

   assign rx_s  = sync_q[SYNC_STAGES-1];
   assign voted = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx};
      samp_d = sample_en ? {samp_q[0], rx_s} : samp_q;
   end

   // NOTE: the chain resets to 1 (idle line) so releasing reset can never look like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
         samp_q <= '1;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         sync_q <= sync_d;
         samp_q <= samp_d;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: optional parity, one/two stop bits,
// majority-voted sampling, false-start rejection and break detection.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT        = 8,
   parameter int OS_TICK     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   input  logic [1:0]      parity_mode,
   input  logic            two_stop,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            parity_err,
   output logic            frame_err,
   output logic            break_det
);

   localparam int SW = clog2(OS_TICK);
   localparam int NW = clog2(DBIT);

   localparam logic [SW-1:0] S_MID  = SW'(OS_TICK / 2 - 1);
   localparam logic [SW-1:0] S_SMP0 = SW'(OS_TICK - 3);
   localparam logic [SW-1:0] S_SMP1 = SW'(OS_TICK - 2);
   localparam logic [SW-1:0] S_LAST = SW'(OS_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   rx_state_e       state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] shift_q, shift_d;
   logic [1:0]      mode_q, mode_d;
   logic            two_q, two_d;
   logic            pbit_q, pbit_d;
   logic            ferr_acc_q, ferr_acc_d;
   logic            done_q, done_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            brk_q, brk_d;

   logic rx_s, voted, sample_en, in_bit, bit_end, par_en, stop_bad, par_xor;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .sample_en (sample_en),
      .rx_s      (rx_s),
      .voted     (voted)
   );

   assign par_en    = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
   assign in_bit    = state_q inside {ST_DATA, ST_PARITY, ST_STOP};
   assign bit_end   = s_tick && in_bit && (s_q == S_LAST);
   assign sample_en = s_tick && in_bit && ((s_q == S_SMP0) || (s_q == S_SMP1));
   assign stop_bad  = ferr_acc_q | ~voted;
   assign par_xor   = (^shift_q) ^ pbit_q;

   always_comb begin
      // NOTE: every *_d takes its hold value first, so no path can infer a latch.
      state_d    = state_q;
      s_d        = s_q;
      n_d        = n_q;
      shift_d    = shift_q;
      mode_d     = mode_q;
      two_d      = two_q;
      pbit_d     = pbit_q;
      ferr_acc_d = ferr_acc_q;
      done_d     = 1'b0;
      dout_d     = dout_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;

      // Bit periods share one free-running s counter that wraps on the decision tick.
      if (s_tick && in_bit) begin
         s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      end

      if (s_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d    = ST_START;
                  s_d        = '0;
                  mode_d     = parity_mode;
                  two_d      = two_stop;
                  ferr_acc_d = 1'b0;
               end
            end
            ST_START: begin
               if (s_q == S_MID) begin
                  if (rx_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  shift_d = {voted, shift_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     n_d     = '0;
                     state_d = par_en ? ST_PARITY : ST_STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  pbit_d  = voted;
                  state_d = ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (two_q && (n_q == '0)) begin
                     // First of two stop bits: remember a failure, still sample the second.
                     n_d        = NW'(1);
                     ferr_acc_d = stop_bad;
                  end else begin
                     n_d     = '0;
                     done_d  = 1'b1;
                     dout_d  = shift_q;
                     perr_d  = (mode_q == PAR_EVEN) ? par_xor :
                               (mode_q == PAR_ODD)  ? ~par_xor : 1'b0;
                     ferr_d  = stop_bad;
                     brk_d   = stop_bad && (shift_q == '0) && (!par_en || !pbit_q);
                     state_d = stop_bad ? ST_RECOVER : ST_IDLE;
                  end
               end
            end
            ST_RECOVER: begin
               // A held-low line must go idle before another start bit is accepted.
               if (rx_s) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         n_q        <= '0;
         shift_q    <= '0;
         mode_q     <= PAR_NONE;
         two_q      <= 1'b0;
         pbit_q     <= 1'b0;
         ferr_acc_q <= 1'b0;
         done_q     <= 1'b0;
         dout_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         n_q        <= n_d;
         shift_q    <= shift_d;
         mode_q     <= mode_d;
         two_q      <= two_d;
         pbit_q     <= pbit_d;
         ferr_acc_q <= ferr_acc_d;
         done_q     <= done_d;
         dout_q     <= dout_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
      end
   end

   assign rx_done_tick = done_q;
   assign dout         = dout_q;
   assign parity_err   = perr_q;
   assign frame_err    = ferr_q;
   assign break_det    = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames
// compared against a frame-level model of the receiver.
module tb_uart_rx_cfg;

   localparam int DBIT = 8;
   localparam int OS   = 16;

   typedef struct packed {
      logic [DBIT-1:0] dout;
      logic            perr;
      logic            ferr;
      logic            brk;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rx = 1'b1;
   logic            s_tick = 1'b1;
   logic [1:0]      parity_mode = 2'b00;
   logic            two_stop = 1'b0;
   logic            rx_done_tick;
   logic [DBIT-1:0] dout;
   logic            parity_err;
   logic            frame_err;
   logic            break_det;

   int vectors     = 0;
   int miscompares = 0;

   int              done_cnt = 0;
   logic [DBIT-1:0] cap_dout;
   logic            cap_perr, cap_ferr, cap_brk;
   exp_t            last_exp;

   always #5 clk = ~clk;

   uart_rx_cfg #(
      .DBIT(DBIT), .OS_TICK(OS), .SYNC_STAGES(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .parity_mode  (parity_mode),
      .two_stop     (two_stop),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .parity_err   (parity_err),
      .frame_err    (frame_err),
      .break_det    (break_det)
   );

   // Every clock the pulse is high counts, so a two-cycle pulse shows up as an extra frame.
   always @(negedge clk) begin
      if (rx_done_tick === 1'b1) begin
         done_cnt++;
         cap_dout = dout;
         cap_perr = parity_err;
         cap_ferr = frame_err;
         cap_brk  = break_det;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   // Frame-level expectation from the line contents alone.
   function automatic exp_t model_frame(input logic [DBIT-1:0] data, input logic [1:0] mode,
                                        input logic pbit, input logic two,
                                        input logic stop1, input logic stop2);
      exp_t e;
      int   ones;
      logic par_on;
      par_on = (mode == 2'b01) || (mode == 2'b10);
      ones   = $countones(data) + (pbit ? 1 : 0);
      e.dout = data;
      if (mode == 2'b01)      e.perr = (ones % 2) == 1;
      else if (mode == 2'b10) e.perr = (ones % 2) == 0;
      else                    e.perr = 1'b0;
      e.ferr = !stop1 || (two && !stop2);
      e.brk  = e.ferr && (data == '0) && (!par_on || !pbit);
      return e;
   endfunction

   // All drives happen 1 time unit after a rising edge; each bit lasts OS clocks.
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (OS) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Configuration pins are scrambled once the start bit is on the line.
   task automatic send_frame(input logic [DBIT-1:0] data, input logic [1:0] mode,
                             input logic pbit, input logic two,
                             input logic stop1, input logic stop2);
      parity_mode = mode;
      two_stop    = two;
      drive_bit(1'b0);
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
      for (int i = 0; i < DBIT; i++) drive_bit(data[i]);
      if (mode == 2'b01 || mode == 2'b10) drive_bit(pbit);
      drive_bit(stop1);
      if (two) drive_bit(stop2);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({dout, parity_err, frame_err, break_det} !== '0) begin
         miscompares++;
         $display("FAIL reset outputs: got dout=%h pe=%b fe=%b bd=%b want all 0", dout, parity_err, frame_err, break_det);
      end
      vectors++;
      if (rx_done_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL reset done: got %b want 0", rx_done_tick);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      idle(4);
   endtask

   task automatic test_8n1();
      exp_t e;
      int   n0;
      n0 = done_cnt;
      e  = model_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(30);
      vectors++;
      if (done_cnt !== n0 + 1) begin
         miscompares++;
         $display("FAIL 8n1 done pulses: got %0d want 1", done_cnt - n0);
      end
      vectors++;
      if ({cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
         miscompares++;
         $display("FAIL 8n1 frame: got %h/%b/%b/%b want %h/%b/%b/%b", cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
      end
      vectors++;
      if ({dout, parity_err, frame_err, break_det} !== e) begin
         miscompares++;
         $display("FAIL 8n1 hold: got %h/%b/%b/%b want %h/%b/%b/%b", dout, parity_err, frame_err, break_det, e.dout, e.perr, e.ferr, e.brk);
      end
      last_exp = e;
   endtask

   task automatic test_parity();
      exp_t e;
      int   n0;
      for (int m = 1; m <= 2; m++) begin
         n0 = done_cnt;
         e  = model_frame(8'hA3, 2'(m), 1'b1, 1'b0, 1'b1, 1'b1);
         send_frame(8'hA3, 2'(m), 1'b1, 1'b0, 1'b1, 1'b1);
         idle(4);
         vectors++;
         if (done_cnt !== n0 + 1) begin
            miscompares++;
            $display("FAIL parity mode %0d done pulses: got %0d want 1", m, done_cnt - n0);
         end
         vectors++;
         if ({cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
            miscompares++;
            $display("FAIL parity mode %0d frame: got %h/%b/%b/%b want %h/%b/%b/%b", m, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
         end
         last_exp = e;
      end
   endtask

   task automatic test_false_start();
      exp_t e;
      int   n0;
      n0 = done_cnt;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(2 * OS);
      vectors++;
      if (done_cnt !== n0) begin
         miscompares++;
         $display("FAIL false start pulses: got %0d want 0", done_cnt - n0);
      end
      vectors++;
      if ({dout, parity_err, frame_err, break_det} !== last_exp) begin
         miscompares++;
         $display("FAIL false start outputs changed: got %h/%b/%b/%b want %h/%b/%b/%b", dout, parity_err, frame_err, break_det, last_exp.dout, last_exp.perr, last_exp.ferr, last_exp.brk);
      end
      e = model_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      vectors++;
      if (done_cnt !== n0 + 1 || {cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
         miscompares++;
         $display("FAIL after false start: got %0d pulses %h/%b/%b/%b want 1 pulse %h/%b/%b/%b", done_cnt - n0, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
      end
      last_exp = e;
   endtask

   // rx_s lags rx by two clocks, the start bit is confirmed at its clock OS/2 and
   // data samples fall OS-3..OS-1 ticks later: clocks OS/2-2..OS/2 of each data bit.
   task automatic test_glitch();
      int   g0 [3] = '{OS / 2 - 1, OS / 2, OS / 2 - 2};
      int   gl [3] = '{1, 2, 2};
      int   hits, n0;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         hits = 0;
         for (int c = OS / 2 - 2; c <= OS / 2; c++)
            if (c >= g0[k] && c < g0[k] + gl[k]) hits++;
         e = model_frame((hits >= 2) ? 8'hF7 : 8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
         n0 = done_cnt;
         parity_mode = 2'b00;
         two_stop    = 1'b0;
         drive_bit(1'b0);
         for (int i = 0; i < DBIT; i++) begin
            if (i == 3) begin
               for (int c = 0; c < OS; c++) begin
                  rx = (c >= g0[k] && c < g0[k] + gl[k]) ? 1'b0 : 1'b1;
                  @(posedge clk);
                  #1;
               end
            end else begin
               drive_bit(1'b1);
            end
         end
         drive_bit(1'b1);
         idle(4);
         vectors++;
         if (done_cnt !== n0 + 1 || {cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
            miscompares++;
            $display("FAIL glitch %0d: got %0d pulses %h/%b/%b/%b want 1 pulse %h/%b/%b/%b", k, done_cnt - n0, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
         end
      end
   endtask

   task automatic test_break();
      exp_t e;
      int   n0;
      n0 = done_cnt;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      rx = 1'b0;
      repeat (20 * OS) @(posedge clk);
      #1;
      e = model_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (done_cnt !== n0 + 1) begin
         miscompares++;
         $display("FAIL break pulses while low: got %0d want 1", done_cnt - n0);
      end
      vectors++;
      if ({cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
         miscompares++;
         $display("FAIL break frame: got %h/%b/%b/%b want %h/%b/%b/%b", cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
      end
      idle(2 * OS);
      vectors++;
      if (done_cnt !== n0 + 1) begin
         miscompares++;
         $display("FAIL break pulses after release: got %0d want 1", done_cnt - n0);
      end
      e = model_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      vectors++;
      if (done_cnt !== n0 + 2 || {cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
         miscompares++;
         $display("FAIL after break: got %0d pulses %h/%b/%b/%b want 2 pulses %h/%b/%b/%b", done_cnt - n0, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
      end
   endtask

   task automatic test_two_stop();
      exp_t e;
      int   n0;
      n0 = done_cnt;
      e  = model_frame(8'h12, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h12, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(8);
      vectors++;
      if (done_cnt !== n0 + 1 || {cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
         miscompares++;
         $display("FAIL two stop: got %0d pulses %h/%b/%b/%b want 1 pulse %h/%b/%b/%b", done_cnt - n0, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_t e;
      int   n0;
      n0 = done_cnt;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      rx    = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rx_done_tick, dout, parity_err, frame_err, break_det} !== '0) begin
         miscompares++;
         $display("FAIL mid-frame reset outputs: got done=%b %h/%b/%b/%b want all 0", rx_done_tick, dout, parity_err, frame_err, break_det);
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(2 * OS);
      vectors++;
      if (done_cnt !== n0) begin
         miscompares++;
         $display("FAIL mid-frame reset pulses: got %0d want 0", done_cnt - n0);
      end
      e = model_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      vectors++;
      if (done_cnt !== n0 + 1 || {cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
         miscompares++;
         $display("FAIL after mid-frame reset: got %0d pulses %h/%b/%b/%b want 1 pulse %h/%b/%b/%b", done_cnt - n0, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
      end
   endtask

   task automatic test_back_to_back();
      exp_t            e;
      int              n0, gap;
      logic [DBIT-1:0] data;
      logic [1:0]      mode;
      logic            pbit, two, st1, st2;
      for (int f = 0; f < 16; f++) begin
         data = DBIT'($urandom);
         mode = 2'($urandom_range(0, 3));
         pbit = 1'($urandom_range(0, 1));
         two  = 1'($urandom_range(0, 1));
         st1  = $urandom_range(0, 5) != 0;
         st2  = $urandom_range(0, 5) != 0;
         if (f == 3) data = '0;
         e  = model_frame(data, mode, pbit, two, st1, st2);
         n0 = done_cnt;
         send_frame(data, mode, pbit, two, st1, st2);
         gap = e.ferr ? $urandom_range(4, 20) : $urandom_range(0, 20);
         idle(gap);
         vectors++;
         if (done_cnt !== n0 + 1 || {cap_dout, cap_perr, cap_ferr, cap_brk} !== e) begin
            miscompares++;
            $display("FAIL random frame %0d (mode %0d two %b): got %0d pulses %h/%b/%b/%b want 1 pulse %h/%b/%b/%b", f, mode, two, done_cnt - n0, cap_dout, cap_perr, cap_ferr, cap_brk, e.dout, e.perr, e.ferr, e.brk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_false_start();
      test_glitch();
      test_break();
      test_two_stop();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
